// File: rtl/wb_release_unit.sv
// wb_release_unit: writeback release stage between execute and the RF/scoreboard.
// Collects results from two FU ports into a small FIFO and drains one result
// per cycle as a registered RF write pulse, mirrored on the scoreboard toggle.
// Results targeting x0 are accepted and discarded.
// Optional build macro: WB_BYPASS_EN -- when the FIFO is empty, the first
// accepted result skips the FIFO and pulses one cycle after accept.
module wb_release_unit #(
   parameter int NUM_ENTRIES = 8,
   parameter int XLEN        = 32,
   parameter int FIFO_DEPTH  = 4,
   localparam int IW = $clog2(NUM_ENTRIES),
   localparam int PW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fu0_valid,
   output logic            fu0_ready,
   input  logic [IW-1:0]   fu0_rd,
   input  logic [XLEN-1:0] fu0_data,
   input  logic            fu1_valid,
   output logic            fu1_ready,
   input  logic [IW-1:0]   fu1_rd,
   input  logic [XLEN-1:0] fu1_data,
   output logic            rf_we,
   output logic [IW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            sb_w_en,
   output logic [IW-1:0]   sb_w_index,
   output logic [CW-1:0]   pending
);

   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [IW-1:0]   rd_q   [FIFO_DEPTH];
   logic [XLEN-1:0] data_q [FIFO_DEPTH];

   logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d, slot1;
   logic [CW-1:0]   cnt_q, cnt_d, free;
   logic            prio_q, prio_d;
   logic            we_q, we_d;
   logic [IW-1:0]   waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            keep0, keep1, byp0, byp1, enq0, enq1, pop;

   // A pop in the same cycle is deliberately not credited, keeping ready off the pop path.
   assign free = DEPTH_C - cnt_q;

   // Ready depends on registered occupancy and priority only, never on valid.
   always_comb begin
      fu0_ready = 1'b0;
      fu1_ready = 1'b0;
      if (!rst) begin
         if (free >= CW'(2)) begin
            fu0_ready = 1'b1;
            fu1_ready = 1'b1;
         end else if (free == CW'(1)) begin
            fu0_ready = ~prio_q;
            fu1_ready = prio_q;
         end
      end
   end

   assign keep0 = fu0_valid & fu0_ready & (fu0_rd != '0);
   assign keep1 = fu1_valid & fu1_ready & (fu1_rd != '0);

`ifdef WB_BYPASS_EN
   // FU0 wins the bypass slot; FU1 only bypasses when FU0 contributes nothing.
   assign byp0 = keep0 & (cnt_q == '0);
   assign byp1 = keep1 & ~keep0 & (cnt_q == '0);
`else
   assign byp0 = 1'b0;
   assign byp1 = 1'b0;
`endif

   assign enq0  = keep0 & ~byp0;
   assign enq1  = keep1 & ~byp1;
   assign pop   = (cnt_q != '0);
   assign slot1 = enq0 ? wptr_q + PW'(1) : wptr_q;

   // Next-state for pointers, occupancy, priority and the output write pulse.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q + PW'(enq0) + PW'(enq1);
      cnt_d   = cnt_q + CW'(enq0) + CW'(enq1) - CW'(pop);
      prio_d  = prio_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (free == CW'(1) && fu0_valid && fu1_valid)
         prio_d = ~prio_q;
      if (pop) begin
         rptr_d  = rptr_q + PW'(1);
         we_d    = 1'b1;
         waddr_d = rd_q[rptr_q];
         wdata_d = data_q[rptr_q];
      end else if (byp0) begin
         we_d    = 1'b1;
         waddr_d = fu0_rd;
         wdata_d = fu0_data;
      end else if (byp1) begin
         we_d    = 1'b1;
         waddr_d = fu1_rd;
         wdata_d = fu1_data;
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         cnt_q   <= '0;
         prio_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // FIFO storage; FU0 lands ahead of FU1 when both enqueue together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (enq0) begin
            rd_q[wptr_q]   <= fu0_rd;
            data_q[wptr_q] <= fu0_data;
         end
         if (enq1) begin
            rd_q[slot1]   <= fu1_rd;
            data_q[slot1] <= fu1_data;
         end
      end
   end

   assign rf_we      = we_q;
   assign sb_w_en    = we_q;
   assign rf_waddr   = waddr_q;
   assign sb_w_index = waddr_q;
   assign rf_wdata   = wdata_q;
   assign pending    = cnt_q;

endmodule

// File: tb/tb_wb_release_unit.sv
// Testbench for wb_release_unit: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based model.
module tb_wb_release_unit;

   localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
   localparam int LAT = 1;
   localparam logic [1:0] ER [8] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
   localparam int         EP [8] = '{0, 1, 2, 3, 3, 3, 3, 2};
`else
   localparam bit BYP = 1'b0;
   localparam int LAT = 2;
   localparam logic [1:0] ER [8] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
   localparam int         EP [8] = '{0, 2, 3, 3, 3, 3, 3, 2};
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fu0_valid = 1'b0, fu1_valid = 1'b0;
   logic        fu0_ready, fu1_ready;
   logic [2:0]  fu0_rd = '0, fu1_rd = '0;
   logic [31:0] fu0_data = '0, fu1_data = '0;
   logic        rf_we, sb_w_en;
   logic [2:0]  rf_waddr, sb_w_index;
   logic [31:0] rf_wdata;
   logic [2:0]  pending;

   wb_release_unit dut (
      .clk(clk), .rst(rst),
      .fu0_valid(fu0_valid), .fu0_ready(fu0_ready), .fu0_rd(fu0_rd), .fu0_data(fu0_data),
      .fu1_valid(fu1_valid), .fu1_ready(fu1_ready), .fu1_rd(fu1_rd), .fu1_data(fu1_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .sb_w_en(sb_w_en), .sb_w_index(sb_w_index), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [2:0] rd; logic [31:0] d; } item_t;
   typedef struct {
      logic v0; logic [2:0] rd0; logic [31:0] d0;
      logic v1; logic [2:0] rd1; logic [31:0] d1;
      logic [1:0] er; int ep;
   } vec_t;

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;

   // model state: results still owed to the RF, in accept order
   item_t q[$];
   logic        m_we = 1'b0, m_prio = 1'b0;
   logic [2:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   // observations of the last sampled cycle
   logic        obs_we, obs_r0, obs_r1;
   logic [2:0]  obs_addr;
   logic [31:0] obs_data;
   int          obs_pend;
   item_t       out_log[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: sample at negedge, compare with model, advance model.
   task automatic cycle();
      int    free;
      logic  r0, r1;
      item_t kept[$];
      item_t it;
      @(negedge clk);
      obs_we = rf_we; obs_r0 = fu0_ready; obs_r1 = fu1_ready;
      obs_addr = rf_waddr; obs_data = rf_wdata; obs_pend = int'(pending);
      if (rf_we === 1'b1) out_log.push_back({rf_waddr, rf_wdata});
      free = DEPTH - q.size();
      r0 = !rst && (free >= 2 || (free == 1 && !m_prio));
      r1 = !rst && (free >= 2 || (free == 1 && m_prio));
      if (chk_en) begin
         check("fu0_ready", fu0_ready, r0);
         check("fu1_ready", fu1_ready, r1);
         check("pending", pending, q.size());
         check("rf_we", rf_we, m_we);
         check("sb_w_en", sb_w_en, m_we);
         check("rf_waddr", rf_waddr, m_addr);
         check("sb_w_index", sb_w_index, m_addr);
         check("rf_wdata", rf_wdata, m_data);
      end
      if (rst) begin
         q.delete();
         m_we = 1'b0; m_addr = '0; m_data = '0; m_prio = 1'b0;
      end else begin
         if (fu0_valid && r0 && fu0_rd != 0) kept.push_back({fu0_rd, fu0_data});
         if (fu1_valid && r1 && fu1_rd != 0) kept.push_back({fu1_rd, fu1_data});
         if (q.size() > 0) begin
            it = q.pop_front(); m_we = 1'b1; m_addr = it.rd; m_data = it.d;
         end else if (BYP && kept.size() > 0) begin
            it = kept.pop_front(); m_we = 1'b1; m_addr = it.rd; m_data = it.d;
         end else begin
            m_we = 1'b0;
         end
         foreach (kept[i]) q.push_back(kept[i]);
         if (free == 1 && fu0_valid && fu1_valid) m_prio = ~m_prio;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fu0_valid = 1'b0; fu1_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      vec_t tbl[8];
      int first, pulses, peak;
      logic [2:0] wrap_rd[10];

      cycle();
      chk_en = 1'b1;
      do_reset();

      // Test 1: single result latency and content
      fu0_valid = 1'b1; fu0_rd = 3'd5; fu0_data = 32'hDEADBEEF;
      cycle();
      idle();
      first = -1; pulses = 0; out_log.delete();
      for (int k = 1; k <= 5; k++) begin
         cycle();
         if (obs_we === 1'b1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      check("t1_latency", first, LAT);
      check("t1_pulses", pulses, 1);
      check("t1_addr", (out_log.size() > 0) ? out_log[0].rd : 3'd0, 3'd5);
      check("t1_data", (out_log.size() > 0) ? out_log[0].d : 32'd0, 32'hDEADBEEF);

      // Test 2: simultaneous accept, FU0 ahead of FU1
      fu0_valid = 1'b1; fu0_rd = 3'd3; fu0_data = 32'h33;
      fu1_valid = 1'b1; fu1_rd = 3'd7; fu1_data = 32'h77;
      cycle();
      idle();
      out_log.delete(); peak = 0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (obs_pend > peak) peak = obs_pend;
      end
      check("t2_peak", peak, BYP ? 1 : 2);
      check("t2_count", out_log.size(), 2);
      check("t2_first", (out_log.size() > 0) ? out_log[0].rd : 3'd0, 3'd3);
      check("t2_second", (out_log.size() > 1) ? out_log[1].rd : 3'd0, 3'd7);
      check("t2_drained", obs_pend, 0);

      // Test 3: vector table, both ports held valid into contention
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tbl[i].v0 = (i < 6); tbl[i].rd0 = 3'd1; tbl[i].d0 = 32'h1000 + i;
         tbl[i].v1 = (i < 6); tbl[i].rd1 = 3'd2; tbl[i].d1 = 32'h2000 + i;
         tbl[i].er = ER[i];   tbl[i].ep = EP[i];
      end
      for (int i = 0; i < 8; i++) begin
         fu0_valid = tbl[i].v0; fu0_rd = tbl[i].rd0; fu0_data = tbl[i].d0;
         fu1_valid = tbl[i].v1; fu1_rd = tbl[i].rd1; fu1_data = tbl[i].d1;
         cycle();
         check("tbl_ready", {obs_r0, obs_r1}, tbl[i].er);
         check("tbl_pending", obs_pend, tbl[i].ep);
      end
      idle();
      for (int k = 0; k < 6; k++) cycle();

      // Test 4: x0 result handshakes but never writes
      fu1_valid = 1'b1; fu1_rd = 3'd0; fu1_data = 32'hBAD;
      cycle();
      check("t4_ready", obs_r1, 1'b1);
      idle();
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         pulses += int'(obs_we);
      end
      check("t4_pulses", pulses, 0);
      check("t4_pending", obs_pend, 0);

      // Test 5: reset with buffered results
      fu0_valid = 1'b1; fu0_rd = 3'd4; fu0_data = 32'h44;
      fu1_valid = 1'b1; fu1_rd = 3'd6; fu1_data = 32'h66;
      for (int k = 0; k < 4; k++) cycle();
      idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (k == 0) begin
            check("t5_ready", {obs_r0, obs_r1}, 2'b11);
            check("t5_pending", obs_pend, 0);
            check("t5_outs", {obs_addr, obs_data}, 35'd0);
         end
         pulses += int'(obs_we);
      end
      check("t5_pulses", pulses, 0);

      // Test 6: pointer wrap with a stream through FU0
      wrap_rd = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
      out_log.delete();
      for (int i = 0; i < 10; i++) begin
         fu0_valid = 1'b1; fu0_rd = wrap_rd[i]; fu0_data = 32'hA000 + i;
         cycle();
      end
      idle();
      for (int k = 0; k < 6; k++) cycle();
      check("t6_count", out_log.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < out_log.size()) begin
            check("t6_rd", out_log[i].rd, wrap_rd[i]);
            check("t6_data", out_log[i].d, 32'hA000 + i);
         end
      end

      // Randomized traffic against the model
      for (int k = 0; k < 500; k++) begin
         rst = ($urandom_range(0, 63) == 0);
         fu0_valid = $urandom_range(0, 1); fu0_rd = 3'($urandom_range(0, 7)); fu0_data = $urandom;
         fu1_valid = $urandom_range(0, 1); fu1_rd = 3'($urandom_range(0, 7)); fu1_data = $urandom;
         cycle();
      end
      rst = 1'b0;
      idle();
      for (int k = 0; k < 8; k++) cycle();
      check("final_pending", obs_pend, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
